// File: rtl/lms_cmult_sched.sv
// Adaptive complex-LMS tap sequencer: time-shares one external pipelined complex
// multiplier between the output pass y = x*conj(w) and the gradient pass dw = x*conj(r - y).
module lms_cmult_sched #(
    parameter int          MULT_LAT = 2,
    parameter int          MU_SHIFT = 20,
    parameter logic [15:0] W_INIT_R = 16'h7FFF,
    parameter logic [15:0] W_INIT_I = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_valid,
    input  logic [15:0] xr,
    input  logic [15:0] xi,
    input  logic [15:0] rr,
    input  logic [15:0] ri,
    input  logic        adapt_en,
    input  logic        w_load,
    input  logic [15:0] w_ld_r,
    input  logic [15:0] w_ld_i,
    input  logic        ovr_clr,
    output logic [15:0] m_ar,
    output logic [15:0] m_ai,
    output logic [15:0] m_br,
    output logic [15:0] m_bi,
    input  logic [32:0] m_pr,
    input  logic [32:0] m_pi,
    output logic        ready,
    output logic        y_valid,
    output logic [15:0] yr,
    output logic [15:0] yi,
    output logic [15:0] wr,
    output logic [15:0] wi,
    output logic        overrun
);

    localparam int            CW  = (MULT_LAT < 2) ? 1 : $clog2(MULT_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MULT_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRV_Y,
        S_WAIT_Y,
        S_DRV_DW,
        S_WAIT_DW
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   xr_q, xi_q, rr_q, ri_q;
    logic [15:0]   ec_r, ec_i;
    logic [17:0]   ec_r_raw, ec_i_raw;
    logic [15:0]   neg_wi, dw_r, dw_i;
    logic          drop;

    function automatic logic [15:0] sat16(input logic [17:0] v);
        if (!v[17] && v[16:15] != 2'b00)
            return 16'h7FFF;
        else if (v[17] && v[16:15] != 2'b11)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    always_comb begin
        // 18-bit difference so the 17-bit operands can never wrap before saturation
        ec_r_raw = {{2{rr_q[15]}}, rr_q} - {m_pr[31], m_pr[31:15]};
        ec_i_raw = {m_pi[31], m_pi[31:15]} - {{2{ri_q[15]}}, ri_q};
        neg_wi   = 16'd0 - wi;
        dw_r     = 16'($signed(m_pr) >>> MU_SHIFT);
        dw_i     = 16'($signed(m_pi) >>> MU_SHIFT);
        drop     = x_valid & ~ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready   <= 1'b1;
            y_valid <= 1'b0;
            yr      <= '0;
            yi      <= '0;
            overrun <= 1'b0;
            m_ar    <= '0;
            m_ai    <= '0;
            m_br    <= '0;
            m_bi    <= '0;
            wr      <= W_INIT_R;
            wi      <= W_INIT_I;
            xr_q    <= '0;
            xi_q    <= '0;
            rr_q    <= '0;
            ri_q    <= '0;
            ec_r    <= '0;
            ec_i    <= '0;
        end else begin
            y_valid <= 1'b0;
            if (drop)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (x_valid) begin
                        xr_q  <= xr;
                        xi_q  <= xi;
                        rr_q  <= rr;
                        ri_q  <= ri;
                        ready <= 1'b0;
                        state <= S_DRV_Y;
                    end else if (w_load) begin
                        wr <= w_ld_r;
                        wi <= w_ld_i;
                    end
                end
                S_DRV_Y: begin
                    m_ar  <= xr_q;
                    m_ai  <= xi_q;
                    m_br  <= wr;
                    m_bi  <= neg_wi;
                    cnt   <= LAT;
                    state <= S_WAIT_Y;
                end
                S_WAIT_Y: begin
                    if (cnt == '0) begin
                        yr      <= m_pr[30:15];
                        yi      <= m_pi[30:15];
                        y_valid <= 1'b1;
                        ec_r    <= sat16(ec_r_raw);
                        ec_i    <= sat16(ec_i_raw);
                        state   <= S_DRV_DW;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DRV_DW: begin
                    m_ar  <= xr_q;
                    m_ai  <= xi_q;
                    m_br  <= ec_r;
                    m_bi  <= ec_i;
                    cnt   <= LAT;
                    state <= S_WAIT_DW;
                end
                S_WAIT_DW: begin
                    if (cnt == '0) begin
                        if (adapt_en) begin
                            wr <= wr + dw_r;
                            wi <= wi + dw_i;
                        end
                        if (x_valid) begin
                            xr_q  <= xr;
                            xi_q  <= xi;
                            rr_q  <= rr;
                            ri_q  <= ri;
                            ready <= 1'b0;
                            state <= S_DRV_Y;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        // raise ready one cycle early so a sample can land on the update edge
                        if (cnt == CW'(1))
                            ready <= 1'b1;
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lms_cmult_sched.md
Name: lms_cmult_sched

Overview:
- Sequencer for one adaptive complex-LMS tap that shares a single pipelined complex multiplier between two passes per sample.
- Pass Y computes y = x·conj(w). Pass DW computes dw = x·conj(r − y). The weight w is then updated.
- Replaces the two-multiplier mismatch-correction datapath. It sits between the sample-rate front end (one x_valid per sample) and an external complex-multiplier instance.

Parameters:
- MULT_LAT, 2, pipeline latency of the external complex multiplier in clocks (≥1).
- MU_SHIFT, 20, arithmetic right shift applied to the 33-bit dw product (step size).
- W_INIT_R, 16'h7FFF, real weight value after reset.
- W_INIT_I, 16'h0000, imaginary weight value after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- x_valid  in  1  one-cycle sample strobe
- xr, xi  in  16 each  signed input sample
- rr, ri  in  16 each  signed reference sample
- adapt_en  in  1  1 = update weights; 0 = freeze
- w_load  in  1  one-cycle strobe: load w_ld_r/w_ld_i into the weight
- w_ld_r, w_ld_i  in  16 each  signed weight load value
- ovr_clr  in  1  clears overrun
- m_ar, m_ai, m_br, m_bi  out  16 each  registered multiplier operands
- m_pr, m_pi  in  33 each  multiplier products: real = ar·br − ai·bi, imag = ar·bi + ai·br
- ready  out  1  a sample can be accepted this cycle
- y_valid  out  1  one-cycle strobe, yr/yi updated
- yr, yi  out  16 each  signed output
- wr, wi  out  16 each  current weight
- overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset (asynchronous): FSM to IDLE. ready=1. y_valid=0, yr=yi=0, overrun=0. All m_* operands = 0. wr=W_INIT_R, wi=W_INIT_I. Internal x, r and e registers = 0.
- Reset asserted mid-operation aborts the passes. No y_valid is produced and the weight is not modified beyond its reset value.
- Timing is stated in edges; edge 0 is the edge that samples x_valid=1 with ready=1.
  - Edge 0: latch x and r.
  - Edge 1: drive m_a = x, m_b = (wr, −wi). −wi is a 16-bit wrapping negate, so −(−32768) = −32768.
  - Edge 1+MULT_LAT: product is valid on m_p.
  - Edge 2+MULT_LAT: yr = m_pr[30:15], yi = m_pi[30:15]; y_valid=1 for exactly one cycle. Also latch the 17-bit error ec_r = sext(rr) − m_pr[31:15] and ec_i = m_pi[31:15] − sext(ri), each saturated to 16 bits (±32767/−32768).
  - Edge 3+MULT_LAT: drive m_a = x, m_b = (ec_r, ec_i).
  - Edge 4+2·MULT_LAT: if adapt_en=1, w += (dw >>> MU_SHIFT) truncated to 16 bits, wrapping. The shift is arithmetic (floor). adapt_en is sampled at this edge.
- ready=1 in IDLE and in the cycle ending at the update edge. A new sample may therefore be accepted on the update edge, giving a minimum sample period of 4+2·MULT_LAT clocks (8 at default). ready=0 otherwise.
- x_valid=1 while ready=0: the sample is dropped, overrun is set, and the FSM is unaffected.
- overrun stays set until ovr_clr=1, which clears it on the next edge. A simultaneous drop and ovr_clr leaves overrun=1.
- w_load=1 is honoured only while the FSM is in IDLE and x_valid=0; it loads w at that edge. Otherwise it is ignored.
- w_load and x_valid in the same IDLE cycle: the sample is accepted and the load is ignored.
- Operand outputs hold their last values between passes.
- m_p is sampled only at the two capture edges; other values on it are don't-care.

Test Plan:
- Reset, x=(0x4000,0), r=(0x4000,0), adapt_en=1 → y_valid 4 clocks after edge 0; yr=0x3FFF, yi=0; ec_r=1; dw_r>>>20 = 0, so w stays (0x7FFF,0); overrun=0.
- After reset, x=(0x4000,0), r=(0,0), adapt_en=1 → yr=0x3FFF; ec_r=−0x3FFF; wr becomes 0x7EFF at edge 8; wi=0. Repeating with adapt_en=0 leaves w=(0x7FFF,0).
- Samples every 8 clocks for 100 samples using a behavioural multiplier model with MULT_LAT=2 and random data → yr/yi/wr/wi bit-match a golden C model; overrun never set. Rerun with MULT_LAT=3 at a 10-clock period.
- Second x_valid 3 clocks after the first → dropped, overrun=1, only one y_valid. Assert ovr_clr → overrun=0 next cycle.
- IDLE: w_load with (0x1234,0xFEDC) → wr/wi=0x1234/0xFEDC next cycle. w_load during busy → ignored. w_load together with x_valid → sample processed, load ignored.
- rst pulsed at edge 3 of a pass → no y_valid, w=(0x7FFF,0), ready=1. The next sample is processed normally.
